// File: rtl/rab_reset_sequencer.sv
// rtl/rab_reset_sequencer.sv - staggered multi-domain reset release, settle, and watchdog-bounded run sequencer
module rab_reset_sequencer #(
    parameter int NUM_DOMAINS    = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int STAGGER_CYCLES = 1,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   done_i,
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic                   ready_o,
    output logic                   finished_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycle_cnt_o
);

    localparam int M1     = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int M2     = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
    localparam int PH_MAX = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [PH_W-1:0]  HOLD_LAST    = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  STAG_LAST    = PH_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [PH_W-1:0]  SETTLE_LAST  = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  TIMEOUT_LAST = PH_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ASSERT  = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    logic [2:0]       state;
    logic [PH_W-1:0]  phase;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = (&cycle_cnt_o) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            phase       <= '0;
            idx         <= '0;
            rst_no      <= '0;
            ready_o     <= 1'b0;
            finished_o  <= 1'b0;
            timeout_o   <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (start_i) begin
                        state       <= ST_ASSERT;
                        phase       <= '0;
                        idx         <= '0;
                        rst_no      <= '0;
                        finished_o  <= 1'b0;
                        timeout_o   <= 1'b0;
                        cycle_cnt_o <= '0;
                    end
                end
                ST_ASSERT: begin
                    if (phase == HOLD_LAST) begin
                        phase <= '0;
                        // With no stagger every domain leaves reset on the same edge.
                        if (STAGGER_CYCLES == 0 || NUM_DOMAINS == 1) begin
                            rst_no <= '1;
                            state  <= ST_SETTLE;
                        end else begin
                            rst_no[0] <= 1'b1;
                            idx       <= IDX_W'(1);
                            state     <= ST_RELEASE;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (phase == STAG_LAST) begin
                        phase       <= '0;
                        rst_no[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= ST_SETTLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (phase == SETTLE_LAST) begin
                        phase   <= '0;
                        state   <= ST_RUN;
                        ready_o <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_RUN: begin
                    if (done_i) begin
                        state      <= ST_FINISH;
                        ready_o    <= 1'b0;
                        finished_o <= 1'b1;
                        timeout_o  <= 1'b0;
                    end else begin
                        cycle_cnt_o <= cnt_next;
                        // phase tracks RUN cycles only when the watchdog is enabled, so it never wraps.
                        if (TIMEOUT_CYCLES > 0) begin
                            if (phase == TIMEOUT_LAST) begin
                                state      <= ST_FINISH;
                                ready_o    <= 1'b0;
                                finished_o <= 1'b1;
                                timeout_o  <= 1'b1;
                            end else begin
                                phase <= phase + PH_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rab_reset_sequencer.sv
// tb/tb_rab_reset_sequencer.sv - randomized self-checking bench for rab_reset_sequencer across four parameter sets
module tb_rab_reset_sequencer;

    typedef struct packed {
        logic [3:0]  rn;
        logic        rdy;
        logic        fin;
        logic        to;
        logic [15:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst, start, done;

    logic [1:0]  rn_a, rn_b;
    logic [3:0]  rn_c, rn_d;
    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic        fin_a, fin_b, fin_c, fin_d;
    logic        to_a, to_b, to_c, to_d;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [7:0]  cnt_d;

    int checks = 0;
    int fails  = 0;

    int p_n[4]   = '{2, 2, 4, 4};
    int p_h[4]   = '{2, 2, 2, 3};
    int p_s[4]   = '{1, 1, 3, 0};
    int p_se[4]  = '{1, 1, 2, 1};
    int p_t[4]   = '{0, 5, 0, 0};
    int p_max[4] = '{65535, 65535, 15, 255};

    always #5 clk = ~clk;

    rab_reset_sequencer u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .done_i(done),
        .rst_no(rn_a), .ready_o(rdy_a), .finished_o(fin_a), .timeout_o(to_a), .cycle_cnt_o(cnt_a)
    );

    rab_reset_sequencer #(.TIMEOUT_CYCLES(5)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .done_i(done),
        .rst_no(rn_b), .ready_o(rdy_b), .finished_o(fin_b), .timeout_o(to_b), .cycle_cnt_o(cnt_b)
    );

    rab_reset_sequencer #(.NUM_DOMAINS(4), .STAGGER_CYCLES(3), .SETTLE_CYCLES(2), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start), .done_i(done),
        .rst_no(rn_c), .ready_o(rdy_c), .finished_o(fin_c), .timeout_o(to_c), .cycle_cnt_o(cnt_c)
    );

    rab_reset_sequencer #(.NUM_DOMAINS(4), .STAGGER_CYCLES(0), .HOLD_CYCLES(3), .CNT_W(8)) u_d (
        .clk_i(clk), .rst_i(rst), .start_i(start), .done_i(done),
        .rst_no(rn_d), .ready_o(rdy_d), .finished_o(fin_d), .timeout_o(to_d), .cycle_cnt_o(cnt_d)
    );

    function automatic obs_t observe(int i);
        obs_t o;
        case (i)
            0:       o = '{rn: {2'b00, rn_a}, rdy: rdy_a, fin: fin_a, to: to_a, cnt: cnt_a};
            1:       o = '{rn: {2'b00, rn_b}, rdy: rdy_b, fin: fin_b, to: to_b, cnt: cnt_b};
            2:       o = '{rn: rn_c, rdy: rdy_c, fin: fin_c, to: to_c, cnt: {12'd0, cnt_c}};
            default: o = '{rn: rn_d, rdy: rdy_d, fin: fin_d, to: to_d, cnt: {8'd0, cnt_d}};
        endcase
        return o;
    endfunction

    // Expected outputs after edge t of a sequence started at edge 0, with done_i high only at edge d.
    function automatic obs_t model(int i, int t, int d);
        obs_t m;
        int r, dd, f, fin_cnt, c;
        bit tf;
        r       = p_h[i] + (p_n[i] - 1) * p_s[i] + p_se[i];
        dd      = (d > r) ? d : (1 << 30);
        tf      = (p_t[i] > 0) && (r + p_t[i] < dd);
        f       = tf ? r + p_t[i] : dd;
        fin_cnt = tf ? p_t[i] : f - r - 1;
        m = '0;
        for (int k = 0; k < 4; k++)
            if (k < p_n[i]) m.rn[k] = (t >= p_h[i] + k * p_s[i]);
        m.rdy = (t >= r) && (t < f);
        m.fin = (t >= f);
        m.to  = m.fin && tf;
        c = (t <= r) ? 0 : ((t < f) ? t - r : fin_cnt);
        if (c > p_max[i]) c = p_max[i];
        m.cnt = 16'(c);
        return m;
    endfunction

    task automatic test_reset();
        obs_t o;
        rst = 1'b1; start = 1'b1; done = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                o = observe(i);
                checks++;
                if (o !== obs_t'(0)) begin
                    fails++;
                    $display("FAIL reset dut%0d cyc=%0d got=%h required=0", i, n, o);
                end
            end
        end
        rst = 1'b0; start = 1'b0; done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            o = observe(i);
            checks++;
            if (o !== obs_t'(0)) begin
                fails++;
                $display("FAIL idle dut%0d got=%h required=0", i, o);
            end
        end
    endtask

    // done after 10 RUN cycles on the default instance; extra start at edge 3 must be ignored.
    task automatic test_sequence();
        obs_t o, e;
        for (int t = 0; t <= 20; t++) begin
            start = (t == 0) || (t == 3);
            done  = (t == 15);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                o = observe(i); e = model(i, t, 15);
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL sequence dut%0d t=%0d got rn=%h rdy=%b fin=%b to=%b cnt=%0d required rn=%h rdy=%b fin=%b to=%b cnt=%0d",
                             i, t, o.rn, o.rdy, o.fin, o.to, o.cnt, e.rn, e.rdy, e.fin, e.to, e.cnt);
                end
            end
        end
        start = 1'b0; done = 1'b0;
    endtask

    // Restarts from FINISH with random run lengths; the first pass is long enough to saturate u_c.
    task automatic test_restart();
        obs_t o, e;
        int d;
        for (int p = 0; p < 7; p++) begin
            d = (p == 0) ? 35 : int'($urandom_range(14, 40));
            for (int t = 0; t <= d + 3; t++) begin
                start = (t == 0);
                done  = (t == d);
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    o = observe(i); e = model(i, t, d);
                    checks++;
                    if (o !== e) begin
                        fails++;
                        $display("FAIL restart dut%0d d=%0d t=%0d got rn=%h rdy=%b fin=%b to=%b cnt=%0d required rn=%h rdy=%b fin=%b to=%b cnt=%0d",
                                 i, d, t, o.rn, o.rdy, o.fin, o.to, o.cnt, e.rn, e.rdy, e.fin, e.to, e.cnt);
                    end
                end
            end
        end
        start = 1'b0; done = 1'b0;
    endtask

    // done_i on the same edge the watchdog would fire: done wins on u_b.
    task automatic test_tie();
        obs_t o, e;
        for (int t = 0; t <= 12; t++) begin
            start = (t == 0);
            done  = (t == 9);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                o = observe(i); e = model(i, t, 9);
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL tie dut%0d t=%0d got rn=%h rdy=%b fin=%b to=%b cnt=%0d required rn=%h rdy=%b fin=%b to=%b cnt=%0d",
                             i, t, o.rn, o.rdy, o.fin, o.to, o.cnt, e.rn, e.rdy, e.fin, e.to, e.cnt);
                end
            end
        end
        start = 1'b0; done = 1'b0;
    endtask

    // rst_i while u_a is in RELEASE with rst_no=01 aborts everything back to IDLE.
    task automatic test_abort();
        obs_t o, e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t <= 6; t++) begin
            start = (t == 0);
            rst   = (t == 3);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                o = observe(i);
                e = (t < 3) ? model(i, t, -1) : obs_t'(0);
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL abort dut%0d t=%0d got rn=%h rdy=%b fin=%b to=%b cnt=%0d required rn=%h rdy=%b fin=%b to=%b cnt=%0d",
                             i, t, o.rn, o.rdy, o.fin, o.to, o.cnt, e.rn, e.rdy, e.fin, e.to, e.cnt);
                end
            end
        end
        start = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; done = 1'b0;
        test_reset();
        test_sequence();
        test_restart();
        test_tie();
        test_abort();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
